// File: rtl/inst_ram_pkg.sv
// Shared constants, types and helpers for the 256 x 8 instruction memory.
// Contents:
//   DEPTH, BYTE_W, WORD_W, BYTES_PER_WORD, LAST_ALIGNED : geometry constants
//   byte_t / word_t                                      : storage and fetch types
//   idx_t                                                : lane index wide enough
//                                                          that Address+3 never wraps
//   idx_in_range()                                       : lane index bound check
package inst_ram_pkg;

    localparam int unsigned DEPTH          = 256;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned WORD_W         = 32;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned LAST_ALIGNED   = 252;

    typedef logic [BYTE_W-1:0] byte_t;
    typedef logic [WORD_W-1:0] word_t;
    // 34 bits: a 32-bit Address plus up to 3 cannot overflow, so no wrap-around.
    typedef logic [33:0]       idx_t;

    // True when a byte index addresses a real storage location.
    function automatic logic idx_in_range(input idx_t idx);
        return (idx < idx_t'(DEPTH));
    endfunction

endpackage

// File: rtl/inst_ram_word_assemble.sv
// Big-endian word assembly with zero-fill for out-of-range byte lanes.
// Ports:
//   lane0..lane3 : bytes read at Address+0..Address+3 (lane0 = lowest address)
//   lane_ok      : per-lane in-range bits, bit k qualifies lane k
//   word         : {lane0, lane1, lane2, lane3}, missing lanes forced to 8'h00
module inst_ram_word_assemble
    import inst_ram_pkg::*;
(
    input  byte_t      lane0,
    input  byte_t      lane1,
    input  byte_t      lane2,
    input  byte_t      lane3,
    input  logic [3:0] lane_ok,
    output word_t      word
);

    // Place each lane in its big-endian slot, zeroing lanes beyond the array.
    always_comb begin
        word = {WORD_W{1'b0}};
        if (lane_ok[0]) begin
            word[31:24] = lane0;
        end else begin
            word[31:24] = {BYTE_W{1'b0}};
        end
        if (lane_ok[1]) begin
            word[23:16] = lane1;
        end else begin
            word[23:16] = {BYTE_W{1'b0}};
        end
        if (lane_ok[2]) begin
            word[15:8] = lane2;
        end else begin
            word[15:8] = {BYTE_W{1'b0}};
        end
        if (lane_ok[3]) begin
            word[7:0] = lane3;
        end else begin
            word[7:0] = {BYTE_W{1'b0}};
        end
    end

endmodule

// File: rtl/inst_ram_256x8.sv
// 256 x 8 byte-organised instruction memory with a 32-bit big-endian fetch port.
// Ports:
//   clk, reset     : clock and synchronous active-high reset (clears flags only,
//                    never the Mem contents)
//   Address        : fetch byte address (PC); unaligned fetches are allowed
//   DataOut        : {Mem[A], Mem[A+1], Mem[A+2], Mem[A+3]}, bytes past 255 read 0
//   we/wr_addr/wr_data : byte-wide synchronous load port (ignored during reset)
//   misaligned     : Address[1:0] != 0
//   out_of_range   : Address > 252
//   err_sticky     : latched OR of misaligned | out_of_range, cleared by reset
// Build option: define INST_RAM_OUTREG_EN to register DataOut and both flags
// (one-cycle fetch latency); err_sticky then samples the registered flags.
module inst_ram_256x8
    import inst_ram_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    output logic [31:0] DataOut,
    input  logic        we,
    input  logic [7:0]  wr_addr,
    input  logic [7:0]  wr_data,
    output logic        misaligned,
    output logic        out_of_range,
    output logic        err_sticky
);

    // Storage; name kept as Mem so benches can preload it hierarchically.
    byte_t Mem [0:DEPTH-1];

    idx_t       lane_idx_s [BYTES_PER_WORD];
    byte_t      lane_byte_s [BYTES_PER_WORD];
    logic [3:0] lane_ok_s;
    word_t      word_s;
    logic       misaligned_s;
    logic       out_of_range_s;
    logic       err_s;
    logic       err_sticky_r;

    // Byte lane addressing; out-of-range lanes read an aliased byte that the
    // assembler masks off, so the 8-bit truncation of the index is harmless.
    always_comb begin
        for (int k = 0; k < BYTES_PER_WORD; k++) begin
            lane_idx_s[k]  = idx_t'(Address) + idx_t'(k);
            lane_ok_s[k]   = idx_in_range(lane_idx_s[k]);
            lane_byte_s[k] = Mem[lane_idx_s[k][7:0]];
        end
    end

    inst_ram_word_assemble u_word_assemble (
        .lane0   (lane_byte_s[0]),
        .lane1   (lane_byte_s[1]),
        .lane2   (lane_byte_s[2]),
        .lane3   (lane_byte_s[3]),
        .lane_ok (lane_ok_s),
        .word    (word_s)
    );

    // Status decode straight from the fetch address.
    always_comb begin
        misaligned_s   = (Address[1:0] != 2'b00);
        out_of_range_s = (Address > 32'(LAST_ALIGNED));
    end

    // Load port: reset suppresses writes; Mem itself is never cleared.
    always_ff @(posedge clk) begin
        if (!reset && we) begin
            Mem[wr_addr] <= wr_data;
        end
    end

`ifdef INST_RAM_OUTREG_EN
    word_t dataout_r;
    logic  misaligned_r;
    logic  out_of_range_r;

    // Output stage: one cycle of fetch latency, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            dataout_r      <= {WORD_W{1'b0}};
            misaligned_r   <= 1'b0;
            out_of_range_r <= 1'b0;
        end else begin
            dataout_r      <= word_s;
            misaligned_r   <= misaligned_s;
            out_of_range_r <= out_of_range_s;
        end
    end

    assign DataOut      = dataout_r;
    assign misaligned   = misaligned_r;
    assign out_of_range = out_of_range_r;
    assign err_s        = misaligned_r | out_of_range_r;
`else
    assign DataOut      = word_s;
    assign misaligned   = misaligned_s;
    assign out_of_range = out_of_range_s;
    assign err_s        = misaligned_s | out_of_range_s;
`endif

    // Sticky error: sets on any flagged fetch, only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_sticky_r <= 1'b0;
        end else if (err_s) begin
            err_sticky_r <= 1'b1;
        end
    end

    assign err_sticky = err_sticky_r;

endmodule

// File: tb/tb_inst_ram_256x8.sv
// Directed bench for inst_ram_256x8: preload, aligned/unaligned/boundary
// fetches, sticky error and reset behaviour, load port, sequential program scan.
// Works in both builds; with INST_RAM_OUTREG_EN each fetch waits one edge.
module tb_inst_ram_256x8;

    logic        clk;
    logic        reset;
    logic [31:0] Address;
    logic [31:0] DataOut;
    logic        we;
    logic [7:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        misaligned;
    logic        out_of_range;
    logic        err_sticky;

    logic [7:0]  exp_mem [0:255];
    int          n_vec;
    int          n_mis;

    inst_ram_256x8 dut (
        .clk          (clk),
        .reset        (reset),
        .Address      (Address),
        .DataOut      (DataOut),
        .we           (we),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .misaligned   (misaligned),
        .out_of_range (out_of_range),
        .err_sticky   (err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %08h, want %08h", tag, obs, exp);
        end
    endtask

    // Drive a fetch address at the falling edge and wait until it is visible.
    task automatic fetch(input logic [31:0] a);
        @(negedge clk);
        Address = a;
`ifdef INST_RAM_OUTREG_EN
        @(posedge clk);
`endif
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        n_vec   = 0;
        n_mis   = 0;
        reset   = 1'b1;
        we      = 1'b0;
        wr_addr = 8'h00;
        wr_data = 8'h00;
        Address = 32'h0000_0000;

        // Background program pattern, then the directed bytes on top.
        for (int i = 0; i < 256; i++) begin
            exp_mem[i] = 8'((i * 7 + 3) & 8'hFF);
        end
        exp_mem[0]   = 8'hE3; exp_mem[1]   = 8'hA0; exp_mem[2]   = 8'h10; exp_mem[3]   = 8'h05;
        exp_mem[4]   = 8'h12; exp_mem[5]   = 8'h34; exp_mem[6]   = 8'h56; exp_mem[7]   = 8'h78;
        exp_mem[8]   = 8'h11; exp_mem[9]   = 8'h22; exp_mem[10]  = 8'h33; exp_mem[11]  = 8'h44;
        exp_mem[252] = 8'hDE; exp_mem[253] = 8'hAD; exp_mem[254] = 8'hBE; exp_mem[255] = 8'hEF;
        for (int i = 0; i < 256; i++) begin
            dut.Mem[i] = exp_mem[i];
        end

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        check_val("rst_sticky", {31'd0, err_sticky}, 32'd0);
`ifdef INST_RAM_OUTREG_EN
        check_val("rst_dataout", DataOut, 32'h0000_0000);
`endif
        @(negedge clk);
        reset = 1'b0;

        // Aligned fetch at 0
        fetch(32'd0);
        check_val("a0_data", DataOut, 32'hE3A0_1005);
        check_val("a0_mis",  {31'd0, misaligned},   32'd0);
        check_val("a0_oor",  {31'd0, out_of_range}, 32'd0);

        // Unaligned fetch at 1 and sticky error
        fetch(32'd1);
        check_val("a1_data", DataOut, 32'hA010_0512);
        check_val("a1_mis",  {31'd0, misaligned}, 32'd1);
        @(posedge clk);
        #1;
        check_val("a1_sticky", {31'd0, err_sticky}, 32'd1);

        // Reset clears sticky but keeps the memory
        @(negedge clk);
        Address = 32'd4;
        reset   = 1'b1;
        @(posedge clk);
        #1;
        check_val("rst_clr_sticky", {31'd0, err_sticky}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        fetch(32'd4);
        check_val("a4_data", DataOut, 32'h1234_5678);
        fetch(32'd0);
        check_val("a0_kept", DataOut, 32'hE3A0_1005);

        // Top-of-array boundaries
        fetch(32'd252);
        check_val("a252_data", DataOut, 32'hDEAD_BEEF);
        check_val("a252_oor",  {31'd0, out_of_range}, 32'd0);
        fetch(32'd254);
        check_val("a254_data", DataOut, 32'hBEEF_0000);
        check_val("a254_oor",  {31'd0, out_of_range}, 32'd1);
        check_val("a254_mis",  {31'd0, misaligned},   32'd1);
        fetch(32'd256);
        check_val("a256_data", DataOut, 32'h0000_0000);
        check_val("a256_oor",  {31'd0, out_of_range}, 32'd1);
        fetch(32'hFFFF_FFFE);
        check_val("amax_data", DataOut, 32'h0000_0000);

        // Load port write shows on the next fetch of that byte
        fetch(32'd8);
        check_val("wr_before", {24'd0, DataOut[31:24]}, 32'h0000_0011);
        @(negedge clk);
        we      = 1'b1;
        wr_addr = 8'd8;
        wr_data = 8'hAB;
        @(posedge clk);
`ifdef INST_RAM_OUTREG_EN
        #1;
        we = 1'b0;
        @(posedge clk);
`endif
        #1;
        we = 1'b0;
        check_val("wr_after", {24'd0, DataOut[31:24]}, 32'h0000_00AB);
        exp_mem[8] = 8'hAB;

        // Write ignored during reset
        @(negedge clk);
        we      = 1'b1;
        wr_addr = 8'd9;
        wr_data = 8'hCD;
        reset   = 1'b1;
        @(posedge clk);
        #1;
        we    = 1'b0;
        reset = 1'b0;
        fetch(32'd8);
        check_val("wr_in_reset", DataOut, 32'hAB22_3344);

        // Sequential aligned scan of the whole program
        pulse_reset();
        for (int a = 0; a <= 248; a += 4) begin
            fetch(32'(a));
            check_val("seq_data", DataOut,
                      {exp_mem[a], exp_mem[a+1], exp_mem[a+2], exp_mem[a+3]});
        end
        @(posedge clk);
        #1;
        check_val("seq_sticky", {31'd0, err_sticky}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/inst_ram_256x8.md
Name: inst_ram_256x8

Overview:
- Byte-organised 256 x 8 instruction memory for the pipelined CPU (`main`).
- The IF stage drives `Address` (the PC) and receives a 32-bit big-endian instruction word, read combinationally.
- A byte-wide synchronous load port preloads the program; benches may also write the `Mem` array hierarchically.
- Status flags report misaligned and out-of-range fetches.

Parameters:
- DEPTH, 256, number of bytes in `Mem`.
- BYTE_W, 8, width of one storage location.
- WORD_W, 32, width of `DataOut` (4 bytes).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- Address  input  32  byte address of the instruction fetch (PC).
- DataOut  output  32  instruction word at `Address`.
- we  input  1  load-port write enable.
- wr_addr  input  8  load-port byte address.
- wr_data  input  8  load-port byte data.
- misaligned  output  1  high when Address[1:0] != 0.
- out_of_range  output  1  high when Address > DEPTH-4 (i.e. > 252).
- err_sticky  output  1  latched OR of misaligned | out_of_range.

Behaviour:
- Storage: `Mem` is reg [7:0] Mem[0:255] and must keep that hierarchical name for bench preload.
- Read is combinational, zero latency: DataOut = {Mem[A], Mem[A+1], Mem[A+2], Mem[A+3]}, with A = Address. This is big-endian: the byte at the lowest address is DataOut[31:24].
- Any byte index > 255 reads as 8'h00. There is no wrap-around, so Address = 254 gives {Mem[254], Mem[255], 00, 00}.
- Misaligned addresses are still read as given (unaligned fetch is permitted); only the flag is raised.
- misaligned and out_of_range are combinational from `Address`.
- Write: on a rising clk edge with we=1 and reset=0, Mem[wr_addr] <= wr_data.
  - A write to a byte currently being read shows on DataOut right after that edge; the read path has no bypass.
  - we is ignored while reset=1.
- err_sticky is registered:
  - reset=1 at an edge clears it to 0.
  - Otherwise it sets to 1 on any edge where misaligned | out_of_range = 1, and holds until reset.
- Reset does NOT clear `Mem`, so a preloaded program survives reset. Reset mid-operation affects only err_sticky (and the output registers when the optional feature below is enabled).
- Uninitialised bytes read X in simulation. The bench must preload all bytes it fetches.
- Writing 32-bit values into `Mem` truncates them to bits [7:0].

Optional Feature:
- Macro: INST_RAM_OUTREG_EN.
- Defined:
  - DataOut, misaligned and out_of_range are registered, giving one-cycle read latency.
  - These registers clear to 0 on reset.
  - err_sticky samples the registered flags.
- Undefined: combinational read as above, zero latency.

Decomposition:
- Package inst_ram_pkg holds:
  - constants DEPTH=256, BYTE_W=8, WORD_W=32, BYTES_PER_WORD=4, LAST_ALIGNED=252;
  - typedef byte_t (logic [7:0]);
  - typedef word_t (logic [31:0]).
- One natural sub-module: inst_ram_word_assemble. It takes 4 byte lanes plus per-lane in-range bits and outputs the big-endian word with zero-fill.
- The top level holds the array, the write port and the flags.

Test Plan:
- Preload Mem[0..3] = 8'hE3,A0,10,05, Address=0 -> DataOut=32'hE3A01005, misaligned=0, out_of_range=0.
- Preload Mem[4..7]=8'h12,34,56,78, Address=1 -> DataOut=32'hA0100512, misaligned=1; next edge err_sticky=1; assert reset one cycle -> err_sticky=0, and Mem[0..7] unchanged (Address=4 -> 32'h12345678).
- Mem[252..255]=8'hDE,AD,BE,EF: Address=252 -> 32'hDEADBEEF, out_of_range=0; Address=254 -> 32'hBEEF0000, out_of_range=1; Address=256 -> 32'h00000000.
- Load port: we=1, wr_addr=8, wr_data=8'hAB at edge with Address=8 -> DataOut[31:24] goes from old value to 8'hAB after the edge. Same stimulus with reset=1 -> no write.
- Sequential fetch Address=0,4,8,...,248 of a file-preloaded program -> each DataOut matches its 4 preloaded bytes, and err_sticky stays 0.
- With INST_RAM_OUTREG_EN: Address=0 applied before edge n -> DataOut valid after edge n. Reset -> DataOut=0.
